// File: rtl/outing_pkg.sv
// Shared types and default sizing for the outing-decision initiator.
package outing_pkg;

  // Default group size and reply timeout of the poller.
  localparam int NUM_PER_GROUP_DEF = 32'd2;
  localparam int TIMEOUT_DEF       = 32'd15;

  // Friend index width and WAIT timer width for the default configuration.
  localparam int IDX_W = $clog2(32'd2 * NUM_PER_GROUP_DEF);
  localparam int TMR_W = $clog2(TIMEOUT_DEF + 32'd1);

  // Poll-round sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/outing_poller_reply_timer.sv
// WAIT-state timeout counter: counts enabled cycles from zero and flags the
// cycle in which the count reaches TIMEOUT-1. The flag is registered from the
// next count value, so it is aligned with the count it describes.
module reply_timer #(
  parameter int TIMEOUT  = 32'd15,
  parameter int TMR_BITS = $clog2(TIMEOUT + 32'd1)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_BITS-1:0] LAST_CNT = TMR_BITS'(TIMEOUT - 32'd1);

  logic [TMR_BITS-1:0] r_count;
  logic                r_expired;
  logic [TMR_BITS-1:0] w_count_nx;

  // Next count: clear has priority, otherwise step while enabled.
  always_comb begin
    w_count_nx = r_count;
    if (clear) begin
      w_count_nx = '0;
    end else if (enable) begin
      w_count_nx = r_count + TMR_BITS'(1'b1);
    end else begin
      w_count_nx = r_count;
    end
  end

  // Count register and registered expiry flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_count_nx;
      r_expired <= (w_count_nx == LAST_CNT);
    end
  end

  assign expired = r_expired;

endmodule

// File: rtl/outing_poller.sv
// Initiator side of the outing decision: polls every friend in turn over a
// req/reply handshake, records yes/no/timeout per friend and registers the
// going-out decision when the round completes.
module outing_poller
  import outing_pkg::*;
#(
  parameter int NUM_PER_GROUP = NUM_PER_GROUP_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic                                   start,
  output logic                                   invite_req,
  output logic [$clog2(2*NUM_PER_GROUP)-1:0]     invite_idx,
  input  logic                                   reply_valid,
  input  logic                                   reply_yes,
  output logic                                   busy,
  output logic                                   done,
  output logic [NUM_PER_GROUP-1:0]               hikingClub,
  output logic [NUM_PER_GROUP-1:0]               basketBallTeam,
  output logic [2*NUM_PER_GROUP-1:0]             timeout_mask,
  output logic                                   going_out
);

  localparam int NF       = 32'd2 * NUM_PER_GROUP;
  localparam int IDX_BITS = $clog2(NF);
  localparam int TMR_BITS = $clog2(TIMEOUT + 32'd1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NF - 32'd1);

  // State and result registers.
  state_e              r_state;
  logic [IDX_BITS-1:0] r_idx;
  logic [NF-1:0]       r_result;
  logic [NF-1:0]       r_mask;
  logic                r_invite_req;
  logic                r_busy;
  logic                r_done;
  logic                r_going_out;

  // Next-state values from the sequencer.
  state_e              w_state_nx;
  logic [IDX_BITS-1:0] w_idx_nx;
  logic [NF-1:0]       w_result_nx;
  logic [NF-1:0]       w_mask_nx;
  logic                w_clr_go;
  logic                w_go_nx;
  logic                w_tmr_clear;
  logic                w_tmr_en;
  logic                w_expired;

  // Timeout counter for the friend currently being waited on.
  reply_timer #(
    .TIMEOUT  (TIMEOUT),
    .TMR_BITS (TMR_BITS)
  ) u_reply_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_en),
    .expired (w_expired)
  );

  // Sequencer next-state logic: one WAIT per friend separated by a one-cycle
  // GAP so the invitation returns to zero between friends. The timer is held
  // clear everywhere except while a WAIT is still pending.
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_result_nx = r_result;
    w_mask_nx   = r_mask;
    w_clr_go    = 1'b0;
    w_tmr_clear = 1'b1;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_result_nx = '0;
          w_mask_nx   = '0;
          w_idx_nx    = '0;
          w_clr_go    = 1'b1;
          w_state_nx  = WAIT;
        end else begin
          w_state_nx  = IDLE;
        end
      end
      WAIT: begin
        if (reply_valid) begin
          // A reply beats a simultaneous expiry: no mask bit in that case.
          w_result_nx[r_idx] = reply_yes;
          w_state_nx         = (r_idx == LAST_IDX) ? DONE : GAP;
        end else if (w_expired) begin
          w_result_nx[r_idx] = 1'b0;
          w_mask_nx[r_idx]   = 1'b1;
          w_state_nx         = (r_idx == LAST_IDX) ? DONE : GAP;
        end else begin
          w_tmr_clear = 1'b0;
          w_tmr_en    = 1'b1;
          w_state_nx  = WAIT;
        end
      end
      GAP: begin
        w_idx_nx   = r_idx + IDX_BITS'(1'b1);
        w_state_nx = WAIT;
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Decision from the vectors that will be held during DONE.
  always_comb begin
    w_go_nx = (|w_result_nx[NUM_PER_GROUP-1:0]) & (|w_result_nx[NF-1:NUM_PER_GROUP]);
  end

  // State, index, results and registered handshake/status outputs. Outputs are
  // derived from the next state so they line up with the state they describe.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_result     <= '0;
      r_mask       <= '0;
      r_invite_req <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_going_out  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_result     <= w_result_nx;
      r_mask       <= w_mask_nx;
      r_invite_req <= (w_state_nx == WAIT);
      r_busy       <= (w_state_nx != IDLE);
      r_done       <= (w_state_nx == DONE);
      if (w_clr_go) begin
        r_going_out <= 1'b0;
      end else if (w_state_nx == DONE) begin
        r_going_out <= w_go_nx;
      end else begin
        r_going_out <= r_going_out;
      end
    end
  end

  assign invite_req     = r_invite_req;
  assign invite_idx     = r_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign hikingClub     = r_result[NUM_PER_GROUP-1:0];
  assign basketBallTeam = r_result[NF-1:NUM_PER_GROUP];
  assign timeout_mask   = r_mask;
  assign going_out      = r_going_out;

endmodule

// File: tb/tb_outing_poller.sv
// Bench for outing_poller: scripted and randomized poll rounds compared
// cycle by cycle against a round-level timing/result model.
module tb_outing_poller;

  localparam int N  = 2;
  localparam int NF = 2 * N;
  localparam int TO = 15;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic          invite_req;
  logic [1:0]    invite_idx;
  logic          reply_valid;
  logic          reply_yes;
  logic          busy;
  logic          done;
  logic [N-1:0]  hikingClub;
  logic [N-1:0]  basketBallTeam;
  logic [NF-1:0] timeout_mask;
  logic          going_out;

  outing_poller #(.NUM_PER_GROUP(N), .TIMEOUT(TO)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .start          (start),
    .invite_req     (invite_req),
    .invite_idx     (invite_idx),
    .reply_valid    (reply_valid),
    .reply_yes      (reply_yes),
    .busy           (busy),
    .done           (done),
    .hikingClub     (hikingClub),
    .basketBallTeam (basketBallTeam),
    .timeout_mask   (timeout_mask),
    .going_out      (going_out)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Per-friend script: reply delay in WAIT cycles (-1 or >= TO: never reply)
  // and the answer given.
  int   dly   [NF];
  logic yes_v [NF];

  // Results the DUT should be holding while idle.
  logic [NF-1:0] prev_res;
  logic [NF-1:0] prev_mask;
  logic          prev_go;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_round(input bit noise);
    int ws [NF];
    int wl [NF];
    int t;
    int done_c;
    int kk;
    bit in_wait;
    bit in_gap;
    logic [NF-1:0] er;
    logic [NF-1:0] em;
    logic eg;
    // Model: WAIT for friend k starts after all earlier WAITs plus one GAP each.
    t = 1;
    for (int k = 0; k < NF; k++) begin
      ws[k] = t;
      if (dly[k] >= 0 && dly[k] < TO) begin
        wl[k] = dly[k] + 1;
        er[k] = yes_v[k];
        em[k] = 1'b0;
      end else begin
        wl[k] = TO;
        er[k] = 1'b0;
        em[k] = 1'b1;
      end
      t = t + wl[k] + 1;
    end
    done_c = ws[NF-1] + wl[NF-1];
    eg = (|er[N-1:0]) & (|er[NF-1:N]);
    for (int c = 0; c <= done_c; c++) begin
      @(negedge Clk);
      in_wait = 1'b0;
      in_gap  = 1'b0;
      kk      = 0;
      for (int k = 0; k < NF; k++) begin
        if (c >= ws[k] && c < ws[k] + wl[k]) begin
          in_wait = 1'b1;
          kk      = k;
        end else if (k < NF - 1 && c == ws[k] + wl[k]) begin
          in_gap = 1'b1;
          kk     = k;
        end
      end
      check("busy", 32'(busy), 32'(c >= 1));
      check("done", 32'(done), 32'(c == done_c));
      check("invite_req", 32'(invite_req), 32'(in_wait));
      if (in_wait || in_gap) check("invite_idx", 32'(invite_idx), 32'(kk));
      if (c == 0) begin
        check("held_results", 32'({hikingClub, basketBallTeam}), 32'({prev_res[N-1:0], prev_res[NF-1:N]}));
        check("held_mask", 32'(timeout_mask), 32'(prev_mask));
        check("held_going_out", 32'(going_out), 32'(prev_go));
      end
      if (c == done_c) begin
        check("hikingClub", 32'(hikingClub), 32'(er[N-1:0]));
        check("basketBallTeam", 32'(basketBallTeam), 32'(er[NF-1:N]));
        check("timeout_mask", 32'(timeout_mask), 32'(em));
        check("going_out", 32'(going_out), 32'(eg));
      end
      start = (c == 0) ? 1'b1 : (noise && ($urandom_range(0, 3) == 0));
      if (in_wait) begin
        reply_valid = ((c - ws[kk]) == dly[kk]);
        reply_yes   = reply_valid ? yes_v[kk] : 1'($urandom_range(0, 1));
      end else if (in_gap && noise) begin
        reply_valid = 1'($urandom_range(0, 1));
        reply_yes   = 1'($urandom_range(0, 1));
      end else begin
        reply_valid = 1'b0;
        reply_yes   = 1'b0;
      end
    end
    prev_res  = er;
    prev_mask = em;
    prev_go   = eg;
  endtask

  initial begin
    Rst = 1'b1;
    start = 1'b0;
    reply_valid = 1'b0;
    reply_yes = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(invite_req), 32'd0);
    check("rst_idx", 32'(invite_idx), 32'd0);
    check("rst_vectors", 32'({hikingClub, basketBallTeam, timeout_mask, going_out}), 32'd0);
    Rst = 1'b0;
    prev_res = '0; prev_mask = '0; prev_go = 1'b0;

    // All four yes immediately: done at cycle 8.
    dly = '{0, 0, 0, 0}; yes_v = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_round(1'b0);
    // Hiking 1,0 and basketball 0,0.
    dly = '{0, 0, 0, 0}; yes_v = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_round(1'b0);
    // Friend 2 never replies.
    dly = '{0, 0, -1, 0}; yes_v = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_round(1'b0);
    // Reply in the expiry cycle wins.
    dly = '{0, TO - 1, 0, 0}; yes_v = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_round(1'b0);
    // Stray start while busy and stray replies in GAP.
    dly = '{2, 0, 1, 3}; yes_v = '{1'b0, 1'b1, 1'b1, 1'b0};
    run_round(1'b1);

    // Reset in the WAIT for friend 2 aborts the round.
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0; reply_valid = 1'b1; reply_yes = 1'b1;
    @(negedge Clk); reply_valid = 1'b0;
    @(negedge Clk); reply_valid = 1'b1;
    @(negedge Clk); reply_valid = 1'b0;
    @(negedge Clk);
    check("abort_req", 32'(invite_req), 32'd1);
    check("abort_idx", 32'(invite_idx), 32'd2);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req_clr", 32'(invite_req), 32'd0);
    check("abort_idx_clr", 32'(invite_idx), 32'd0);
    check("abort_vectors", 32'({hikingClub, basketBallTeam, timeout_mask, going_out}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    prev_res = '0; prev_mask = '0; prev_go = 1'b0;
    dly = '{1, 0, 0, 2}; yes_v = '{1'b0, 1'b1, 1'b1, 1'b1};
    run_round(1'b0);

    // Randomized rounds: short delays, near-expiry delays and timeouts.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NF; k++) begin
        case ($urandom_range(0, 3))
          0:       dly[k] = -1;
          1:       dly[k] = $urandom_range(TO - 2, TO + 1);
          default: dly[k] = $urandom_range(0, 3);
        endcase
        yes_v[k] = 1'($urandom_range(0, 1));
      end
      run_round(1'($urandom_range(0, 1)));
    end

    @(negedge Clk);
    start = 1'b0;
    reply_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
